// File: rtl/ex_mdu_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit.
// Latency: n/a (constants, types and helper functions only).
// Backpressure: n/a.
// Contents: RV32M funct3 op codes, FSM state encoding, result-routing (prio) codes,
//           and operand-signedness helpers used by the top level.
package ex_mdu_pkg;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } mduState_t;

    localparam logic [1:0] PRIO_NONE = 2'b00;
    localparam logic [1:0] PRIO_P0   = 2'b10;
    localparam logic [1:0] PRIO_P1   = 2'b11;

    // rs1 is treated as signed by every op except the unsigned variants.
    function automatic logic src1Signed(input logic [2:0] op);
        return !(op == OP_MULHU || op == OP_DIVU || op == OP_REMU);
    endfunction

    // rs2 is signed only for the fully signed ops (MULHSU takes rs2 unsigned).
    function automatic logic src2Signed(input logic [2:0] op);
        return (op == OP_MUL || op == OP_MULH || op == OP_DIV || op == OP_REM);
    endfunction

endpackage

// File: rtl/ex_mdu_div_core.sv
// Restoring-division datapath: unsigned magnitude divide, one subtract-shift step per cycle.
// Latency: DATA_WIDTH steps after load; step results are also exposed combinationally.
// Backpressure: none; advances only when the controller asserts step.
// Ports: clk, rst (sync, active-high); load captures dividend/divisor; step performs one
//        iteration; quoNext/remNext are the register values after the current step.
module ex_mdu_div_core #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  step,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic [DATA_WIDTH-1:0] quoNext,
    output logic [DATA_WIDTH-1:0] remNext
);

    logic [DATA_WIDTH-1:0] quo;
    logic [DATA_WIDTH-1:0] rem;
    logic [DATA_WIDTH-1:0] dvsr;
    logic [DATA_WIDTH:0]   remShift;
    logic [DATA_WIDTH:0]   diff;

    // The quotient register starts as the dividend and is shifted out MSB-first into
    // the partial remainder while quotient bits are shifted in at the bottom.
    // rem < dvsr always holds, so diff fits in DATA_WIDTH+1 bits and its MSB is the borrow.
    always_comb begin
        remShift = {rem, quo[DATA_WIDTH-1]};
        diff     = remShift - {1'b0, dvsr};
        quoNext  = {quo[DATA_WIDTH-2:0], ~diff[DATA_WIDTH]};
        remNext  = diff[DATA_WIDTH] ? remShift[DATA_WIDTH-1:0] : diff[DATA_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            quo  <= '0;
            rem  <= '0;
            dvsr <= '0;
        end else if (load) begin
            quo  <= dividend;
            rem  <= '0;
            dvsr <= divisor;
        end else if (step) begin
            quo  <= quoNext;
            rem  <= remNext;
        end
    end

endmodule

// File: rtl/ex_mdu.sv
// RV32M multiply/divide unit: one op at a time, result pulsed to the execute output mux.
// Latency: 33 cycles iterative, 1 cycle for div-by-zero/overflow, 2 cycles for MUL* with MDU_FAST_MUL_EN.
// Backpressure: mdu_busy high while not idle; req_valid during busy is ignored.
// Ports: clk, rst (sync, active-high); req_valid/req_pipe/req_op/req_src1/req_src2 request;
//        flush kills in-flight work; mdu_busy; mdu_AluData_m result with mdu_m_prio routing.
// Build option: define MDU_FAST_MUL_EN for a single-cycle multiplier (divide stays iterative).
module ex_mdu
    import ex_mdu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_pipe,
    input  logic [2:0]            req_op,
    input  logic [DATA_WIDTH-1:0] req_src1,
    input  logic [DATA_WIDTH-1:0] req_src2,
    input  logic                  flush,
    output logic                  mdu_busy,
    output logic [DATA_WIDTH-1:0] mdu_AluData_m,
    output logic [1:0]            mdu_m_prio
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam int PW = 2 * DATA_WIDTH;
    localparam logic [CW-1:0]         CNT_LAST = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
    localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    mduState_t             state, stateNext;
    logic [2:0]            opReg;
    logic                  pipeReg;
    logic                  negRes;     // sign of product / quotient
    logic                  negRem;     // remainder follows the dividend sign
    logic [DATA_WIDTH-1:0] magA;
    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] mulHi, mulLo;
    logic [DATA_WIDTH-1:0] resultReg;

    logic                  accept;
    logic                  s1Neg, s2Neg;
    logic [DATA_WIDTH-1:0] absA, absB;
    logic                  divZero, divOvf;
    logic [DATA_WIDTH-1:0] specialRes;
    logic [CW-1:0]         loadCnt;
    logic [DATA_WIDTH:0]   mulSum;
    logic [DATA_WIDTH-1:0] mulHiNext, mulLoNext;
    logic [PW-1:0]         prodMag, prodSigned;
    logic [DATA_WIDTH-1:0] quoNext, remNext;
    logic [DATA_WIDTH-1:0] divQ, divR;
    logic [DATA_WIDTH-1:0] finalRes;
    logic                  execStep;

`ifdef MDU_FAST_MUL_EN
    logic [DATA_WIDTH-1:0] magB;
`endif

    // ---------------- accept-side decode ----------------
    always_comb begin
        accept  = (state == ST_IDLE) && req_valid && !flush;
        s1Neg   = src1Signed(req_op) && req_src1[DATA_WIDTH-1];
        s2Neg   = src2Signed(req_op) && req_src2[DATA_WIDTH-1];
        // Negating the most-negative value yields the same bits, which is the correct
        // unsigned magnitude.
        absA    = s1Neg ? -req_src1 : req_src1;
        absB    = s2Neg ? -req_src2 : req_src2;
        divZero = req_op[2] && (req_src2 == '0);
        divOvf  = (req_op == OP_DIV || req_op == OP_REM) &&
                  (req_src1 == MOST_NEG) && (req_src2 == '1);
        // op[1] distinguishes REM/REMU from DIV/DIVU.
        if (divZero)
            specialRes = req_op[1] ? req_src1 : '1;
        else
            specialRes = req_op[1] ? '0 : req_src1;
`ifdef MDU_FAST_MUL_EN
        loadCnt = req_op[2] ? CNT_LAST : '0;
`else
        loadCnt = CNT_LAST;
`endif
    end

    // ---------------- iterative shift-add multiply ----------------
    // {mulHi, mulLo} starts as {0, multiplier}; each step conditionally adds the
    // multiplicand into the high half and shifts the whole pair right by one.
    always_comb begin
        mulSum    = {1'b0, mulHi} + (mulLo[0] ? {1'b0, magA} : '0);
        mulHiNext = mulSum[DATA_WIDTH:1];
        mulLoNext = {mulSum[0], mulLo[DATA_WIDTH-1:1]};
    end

    // ---------------- result assembly ----------------
    always_comb begin
`ifdef MDU_FAST_MUL_EN
        prodMag = PW'(magA) * PW'(magB);
`else
        prodMag = {mulHiNext, mulLoNext};
`endif
        prodSigned = negRes ? -prodMag : prodMag;
        divQ       = negRes ? -quoNext : quoNext;
        divR       = negRem ? -remNext : remNext;
        if (opReg[2])
            finalRes = opReg[1] ? divR : divQ;
        else if (opReg == OP_MUL)
            finalRes = prodSigned[DATA_WIDTH-1:0];
        else
            finalRes = prodSigned[PW-1:DATA_WIDTH];
    end

    assign execStep = (state == ST_EXEC) && !flush;

    ex_mdu_div_core #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_divCore (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .step     (execStep && opReg[2]),
        .dividend (absA),
        .divisor  (absB),
        .quoNext  (quoNext),
        .remNext  (remNext)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            ST_IDLE: if (accept) stateNext = (divZero || divOvf) ? ST_DONE : ST_EXEC;
            ST_EXEC: if (cnt == '0) stateNext = ST_DONE;
            ST_DONE: stateNext = ST_IDLE;
            default: stateNext = ST_IDLE;
        endcase
        if (flush)
            stateNext = ST_IDLE;
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            opReg     <= '0;
            pipeReg   <= 1'b0;
            negRes    <= 1'b0;
            negRem    <= 1'b0;
            magA      <= '0;
            cnt       <= '0;
            mulHi     <= '0;
            mulLo     <= '0;
            resultReg <= '0;
`ifdef MDU_FAST_MUL_EN
            magB      <= '0;
`endif
        end else if (accept) begin
            opReg   <= req_op;
            pipeReg <= req_pipe;
            negRes  <= s1Neg ^ s2Neg;
            negRem  <= s1Neg;
            magA    <= absA;
            cnt     <= loadCnt;
            mulHi   <= '0;
            mulLo   <= absB;
`ifdef MDU_FAST_MUL_EN
            magB    <= absB;
`endif
            if (divZero || divOvf)
                resultReg <= specialRes;
        end else if (execStep) begin
            cnt   <= cnt - CNT_ONE;
            mulHi <= mulHiNext;
            mulLo <= mulLoNext;
            if (cnt == '0)
                resultReg <= finalRes;
        end
    end

    // ---------------- outputs ----------------
    // prio is gated by flush combinationally so a flush landing on DONE drops the pulse.
    assign mdu_busy      = (state != ST_IDLE);
    assign mdu_AluData_m = resultReg;
    assign mdu_m_prio    = ((state == ST_DONE) && !flush) ? (pipeReg ? PRIO_P1 : PRIO_P0)
                                                          : PRIO_NONE;

endmodule
